// File: rtl/dcache_pkg.sv
// dcache_pkg: shared parameters, width helpers and types for the
// N-way data-cache array (dcache_sram_nway and dcache_lru).
package dcache_pkg;

    localparam int DEF_WAYS   = 2;
    localparam int DEF_SETS   = 16;
    localparam int DEF_TAG_W  = 23;
    localparam int DEF_LINE_W = 256;

    function automatic int idx_w(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    typedef struct packed {
        logic                          hit;
        logic [way_w(DEF_WAYS)-1:0]    way;
        logic [DEF_TAG_W-1:0]          tag;
        logic [DEF_LINE_W-1:0]         line;
        logic                          dirty;
    } dcache_rsp_t;

    typedef enum logic {
        WK_IDLE,
        WK_WALK
    } walk_state_e;

endpackage

// File: rtl/dcache_lru.sv
// dcache_lru: per-set true-LRU ages (0 = most recent), touch update,
// victim selection and set re-initialisation for the invalidate walk.
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int WAYS = DEF_WAYS,
    parameter int SETS = DEF_SETS,
    localparam int IW  = idx_w(SETS),
    localparam int WW  = way_w(WAYS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          touch_en,
    input  logic [IW-1:0] touch_set,
    input  logic [WW-1:0] touch_way,
    input  logic          init_en,
    input  logic [IW-1:0] init_set,
    input  logic [IW-1:0] rd_set,
    input  logic [WAYS-1:0] valid,
    output logic [WW-1:0] victim
);

    logic [WW-1:0] age_q [SETS][WAYS];
    logic          found;

    // Victim: lowest invalid way, otherwise the oldest way
    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid[w]) begin
                victim = WW'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[rd_set][w] == WW'(WAYS - 1))
                    victim = WW'(w);
            end
        end
    end

    // Age update: reset/walk restore age[w] = w, touch makes way youngest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= WW'(w);
        end else if (init_en) begin
            for (int w = 0; w < WAYS; w++)
                age_q[init_set][w] <= WW'(w);
        end else if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WW'(w) == touch_way)
                    age_q[touch_set][w] <= '0;
                else if (age_q[touch_set][w] < age_q[touch_set][touch_way])
                    age_q[touch_set][w] <= age_q[touch_set][w] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way set-associative line array, registered responses.
// Optional invalidate-all walker enabled by defining DCACHE_SRAM_INV_EN.
module dcache_sram_nway
    import dcache_pkg::*;
#(
    parameter int WAYS   = DEF_WAYS,
    parameter int SETS   = DEF_SETS,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int LINE_W = DEF_LINE_W,
    localparam int IW    = idx_w(SETS),
    localparam int WW    = way_w(WAYS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic              fill_i,
    input  logic [IW-1:0]     addr_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              inv_i,
    output logic              valid_o,
    output logic              hit_o,
    output logic [WW-1:0]     way_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] data_o,
    output logic              dirty_o,
    output logic              busy_o
);

    logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
    logic [LINE_W-1:0] line_q [SETS][WAYS];
    logic [WAYS-1:0]   vld_q  [SETS];
    logic [WAYS-1:0]   drt_q  [SETS];

    logic          hit;
    logic [WW-1:0] hit_way;
    logic [WW-1:0] victim;
    logic [WW-1:0] tgt_way;
    logic [WW-1:0] rsp_way;
    logic          req;
    logic          wr_hit;
    logic          refill;
    logic          touch_en;
    logic          inv_go;
    logic          walk_en;
    logic [IW-1:0] walk_set;

`ifdef DCACHE_SRAM_INV_EN
    walk_state_e state_q;

    assign inv_go  = inv_i && (state_q == WK_IDLE);
    assign walk_en = (state_q == WK_WALK);

    // Invalidate walker: one set per cycle, busy_o registered with state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= WK_IDLE;
            walk_set <= '0;
            busy_o   <= 1'b0;
        end else begin
            unique case (state_q)
                WK_IDLE: begin
                    if (inv_i) begin
                        state_q  <= WK_WALK;
                        walk_set <= '0;
                        busy_o   <= 1'b1;
                    end
                end
                WK_WALK: begin
                    if (walk_set == IW'(SETS - 1)) begin
                        state_q <= WK_IDLE;
                        busy_o  <= 1'b0;
                    end else begin
                        walk_set <= walk_set + 1'b1;
                    end
                end
                default: state_q <= WK_IDLE;
            endcase
        end
    end
`else
    logic unused_inv;

    assign unused_inv = inv_i;
    assign inv_go     = 1'b0;
    assign walk_en    = 1'b0;
    assign walk_set   = '0;
    assign busy_o     = 1'b0;
`endif

    assign req      = enable_i && !walk_en && !inv_go;
    assign wr_hit   = req && write_i && !fill_i && hit;
    assign refill   = req && write_i && fill_i;
    assign touch_en = (req && !write_i && hit) || wr_hit || refill;
    assign tgt_way  = (refill && !hit) ? victim : hit_way;
    assign rsp_way  = (hit && !refill) ? hit_way : victim;

    // Tag compare across the ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (vld_q[addr_i][w] && tag_q[addr_i][w] == tag_i) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    dcache_lru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .touch_en  (touch_en),
        .touch_set (addr_i),
        .touch_way (tgt_way),
        .init_en   (walk_en),
        .init_set  (walk_set),
        .rd_set    (addr_i),
        .valid     (vld_q[addr_i]),
        .victim    (victim)
    );

    // Tag and line storage; contents need no reset
    always_ff @(posedge clk_i) begin
        if (wr_hit || refill)
            line_q[addr_i][tgt_way] <= data_i;
        if (refill)
            tag_q[addr_i][tgt_way] <= tag_i;
    end

    // Valid/dirty state: cleared by reset and by the walker
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < SETS; s++) begin
                vld_q[s] <= '0;
                drt_q[s] <= '0;
            end
        end else if (walk_en) begin
            vld_q[walk_set] <= '0;
            drt_q[walk_set] <= '0;
        end else if (wr_hit) begin
            drt_q[addr_i][tgt_way] <= 1'b1;
        end else if (refill) begin
            vld_q[addr_i][tgt_way] <= 1'b1;
            drt_q[addr_i][tgt_way] <= 1'b0;
        end
    end

    // Registered response, held until the next accepted request
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o <= 1'b0;
            hit_o   <= 1'b0;
            way_o   <= '0;
            tag_o   <= '0;
            data_o  <= '0;
            dirty_o <= 1'b0;
        end else begin
            valid_o <= req;
            if (req) begin
                hit_o   <= hit && !refill;
                way_o   <= rsp_way;
                tag_o   <= tag_q[addr_i][rsp_way];
                data_o  <= wr_hit ? data_i : line_q[addr_i][rsp_way];
                dirty_o <= wr_hit ? 1'b1 : drt_q[addr_i][rsp_way];
            end
        end
    end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway: directed vectors for dcache_sram_nway (2 ways, 16 sets).
// Invalidate-walk checks apply when DCACHE_SRAM_INV_EN is defined.
module tb_dcache_sram_nway;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         enable_i;
    logic         write_i;
    logic         fill_i;
    logic [3:0]   addr_i;
    logic [22:0]  tag_i;
    logic [255:0] data_i;
    logic         inv_i;
    logic         valid_o;
    logic         hit_o;
    logic [0:0]   way_o;
    logic [22:0]  tag_o;
    logic [255:0] data_o;
    logic         dirty_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] L_AA = {32{8'hAA}};
    localparam logic [255:0] L_55 = {32{8'h55}};
    localparam logic [255:0] L_11 = {32{8'h11}};
    localparam logic [255:0] L_22 = {32{8'h22}};
    localparam logic [255:0] L_33 = {32{8'h33}};
    localparam logic [255:0] L_44 = {32{8'h44}};

    dcache_sram_nway dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .fill_i   (fill_i),
        .addr_i   (addr_i),
        .tag_i    (tag_i),
        .data_i   (data_i),
        .inv_i    (inv_i),
        .valid_o  (valid_o),
        .hit_o    (hit_o),
        .way_o    (way_o),
        .tag_o    (tag_o),
        .data_o   (data_o),
        .dirty_o  (dirty_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Issue one request at the next edge, sample 1 time unit later
    task automatic do_req(input logic wr, input logic fl, input logic [3:0] s,
                          input logic [22:0] t, input logic [255:0] d);
        enable_i = 1'b1;
        write_i  = wr;
        fill_i   = fl;
        addr_i   = s;
        tag_i    = t;
        data_i   = d;
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
    endtask

    initial begin
        int n;
        int seen_valid;
        rst_n_i  = 1'b0;
        enable_i = 1'b0;
        write_i  = 1'b0;
        fill_i   = 1'b0;
        addr_i   = '0;
        tag_i    = '0;
        data_i   = '0;
        inv_i    = 1'b0;
        #12;
        check("rst_valid", 256'(valid_o), 256'(0));
        check("rst_hit", 256'(hit_o), 256'(0));
        check("rst_data", data_o, 256'(0));
        check("rst_busy", 256'(busy_o), 256'(0));
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        do_req(1'b0, 1'b0, 4'd3, 23'h1, '0);
        check("lk_valid", 256'(valid_o), 256'(1));
        check("lk_hit", 256'(hit_o), 256'(0));
        check("lk_way", 256'(way_o), 256'(0));
        check("lk_dirty", 256'(dirty_o), 256'(0));
        @(posedge clk_i); #1;
        check("idle_valid", 256'(valid_o), 256'(0));

        do_req(1'b1, 1'b1, 4'd3, 23'hA, L_AA);
        check("rf_hit", 256'(hit_o), 256'(0));
        check("rf_way", 256'(way_o), 256'(0));
        do_req(1'b0, 1'b0, 4'd3, 23'hA, '0);
        check("rfa_hit", 256'(hit_o), 256'(1));
        check("rfa_way", 256'(way_o), 256'(0));
        check("rfa_data", data_o, L_AA);
        check("rfa_dirty", 256'(dirty_o), 256'(0));

        do_req(1'b1, 1'b1, 4'd5, 23'h1, L_11);
        do_req(1'b1, 1'b1, 4'd5, 23'h2, L_22);
        check("rf2_way", 256'(way_o), 256'(1));
        do_req(1'b0, 1'b0, 4'd5, 23'h1, '0);
        check("lk1_hit", 256'(hit_o), 256'(1));
        do_req(1'b1, 1'b1, 4'd5, 23'h3, L_33);
        check("lru_hit", 256'(hit_o), 256'(0));
        check("lru_way", 256'(way_o), 256'(1));
        check("lru_tag", 256'(tag_o), 256'(23'h2));
        check("lru_data", data_o, L_22);
        do_req(1'b0, 1'b0, 4'd5, 23'h1, '0);
        check("keep1_hit", 256'(hit_o), 256'(1));
        check("keep1_data", data_o, L_11);

        do_req(1'b1, 1'b0, 4'd5, 23'h1, L_55);
        check("wh_hit", 256'(hit_o), 256'(1));
        check("wh_data", data_o, L_55);
        check("wh_dirty", 256'(dirty_o), 256'(1));
        do_req(1'b0, 1'b0, 4'd5, 23'h3, '0);
        check("lk3_way", 256'(way_o), 256'(1));
        do_req(1'b1, 1'b1, 4'd5, 23'h4, L_44);
        check("wb_way", 256'(way_o), 256'(0));
        check("wb_tag", 256'(tag_o), 256'(23'h1));
        check("wb_dirty", 256'(dirty_o), 256'(1));
        check("wb_data", data_o, L_55);
        do_req(1'b0, 1'b0, 4'd5, 23'h4, '0);
        check("lk4_hit", 256'(hit_o), 256'(1));
        check("lk4_dirty", 256'(dirty_o), 256'(0));

        do_req(1'b1, 1'b0, 4'd7, 23'h9, L_55);
        check("wm_valid", 256'(valid_o), 256'(1));
        check("wm_hit", 256'(hit_o), 256'(0));
        do_req(1'b0, 1'b0, 4'd7, 23'h9, '0);
        check("wm_lk_hit", 256'(hit_o), 256'(0));

        do_req(1'b1, 1'b1, 4'd0, 23'hB, L_AA);
        do_req(1'b1, 1'b1, 4'd15, 23'hC, L_55);
        do_req(1'b0, 1'b0, 4'd0, 23'hB, '0);
        check("s0_hit", 256'(hit_o), 256'(1));
        do_req(1'b0, 1'b0, 4'd15, 23'hC, '0);
        check("s15_hit", 256'(hit_o), 256'(1));

        inv_i    = 1'b1;
        enable_i = 1'b1;
        write_i  = 1'b0;
        fill_i   = 1'b0;
        addr_i   = 4'd0;
        tag_i    = 23'hB;
        @(posedge clk_i); #1;
        inv_i = 1'b0;
`ifdef DCACHE_SRAM_INV_EN
        check("inv_drop", 256'(valid_o), 256'(0));
        n = 0;
        seen_valid = 0;
        while (busy_o && n < 40) begin
            n++;
            if (valid_o) seen_valid++;
            @(posedge clk_i); #1;
        end
        if (valid_o) seen_valid++;
        enable_i = 1'b0;
        check("busy_len", 256'(n), 256'(16));
        check("busy_noresp", 256'(seen_valid), 256'(0));
        do_req(1'b0, 1'b0, 4'd0, 23'hB, '0);
        check("inv_s0_hit", 256'(hit_o), 256'(0));
        do_req(1'b0, 1'b0, 4'd15, 23'hC, '0);
        check("inv_s15_hit", 256'(hit_o), 256'(0));
`else
        enable_i = 1'b0;
        n = 0;
        seen_valid = 0;
        check("noinv_valid", 256'(valid_o), 256'(1));
        check("noinv_hit", 256'(hit_o), 256'(1));
        check("noinv_busy", 256'(busy_o), 256'(0));
        do_req(1'b0, 1'b0, 4'd15, 23'hC, '0);
        check("noinv_s15", 256'(hit_o), 256'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
